arith_op_scheduler: RTL

- Shares one multi-cycle arithmetic unit (SUM, SUB, MULT, DIV) between two requesters.
- Arbitrates between the requesters round-robin and sequences each operation through a fixed per-op latency.
- Returns the result to the granted requester with a one-cycle valid pulse.
- Sits between the control FSMs that issue arithmetic work and the shared 32-bit datapath, replacing hard-wired per-state arithmetic.

---
 rtl/arith_pkg.sv | 26 ++
 rtl/arith_unit.sv | 45 ++++
 rtl/arith_op_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arith_pkg
//  Purpose  : Shared encodings for the arithmetic operation scheduler:
//             operation codes, scheduler FSM states and default latencies.
//  Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Operation encodings presented on reqN_op
    localparam logic [1:0] OP_SUM  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    // Scheduler FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Default execute latencies (cycles) for the multi-cycle operations
    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 4;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/arith_unit.sv
`default_nettype none
// ============================================================================
//  Module   : arith_unit
//  Purpose  : Purely combinational unsigned arithmetic core shared by the
//             scheduler. All results are truncated to WIDTH bits.
//  Ports    : op     - operation select (OP_SUM/OP_SUB/OP_MULT/OP_DIV)
//             a, b   - unsigned operands
//             result - operation result
//             div0   - set only for a divide by zero (result is all ones)
//  Revision : 1.0 - initial release
// ============================================================================
module arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (op)
            OP_SUM:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MULT: result = a * b;   // low WIDTH bits of the product
            OP_DIV: begin
                // Divide by zero saturates to all ones and raises the flag
                if (b == '0) begin
                    result = '1;
                    div0   = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            default: result = '0;
        endcase
    end

endmodule : arith_unit
`default_nettype wire

// File: rtl/arith_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : arith_op_scheduler
//  Purpose  : Shares one multi-cycle arithmetic unit between two requesters.
//             Round-robin arbitration in IDLE, fixed per-op execute latency
//             in EXEC, one-cycle one-hot response pulse in RESP.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             reqN_valid/op/a/b/ready    - requester N handshake (N = 0,1)
//             rsp_valid[1:0]             - one-hot result pulse per requester
//             rsp_data, rsp_err          - result and divide-by-zero flag
//             busy                       - scheduler not idle
//             ops_done                   - completed operation count (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module arith_op_scheduler
    import arith_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [31:0]      ops_done
);

    logic [1:0]       r_state;
    logic [31:0]      r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_grant;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic [31:0]      r_ops_done;

    logic             w_idle;
    logic             w_pick1;
    logic             w_hs;
    logic [1:0]       w_sel_op;
    logic [31:0]      w_lat_m1;
    logic [WIDTH-1:0] w_result;
    logic             w_div0;

    assign w_idle = (r_state == S_IDLE);

    // Requester 1 wins when it is the only one asking, or when both ask and
    // requester 0 was served last.
    assign w_pick1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_hs    = w_idle && (req0_valid || req1_valid);

    assign req0_ready = w_idle && req0_valid && !w_pick1;
    assign req1_ready = w_idle && w_pick1;

    assign w_sel_op = w_pick1 ? req1_op : req0_op;

    // Counter preload is latency minus one: EXEC runs lat(op) cycles
    always_comb begin
        w_lat_m1 = '0;
        case (w_sel_op)
            OP_MULT: w_lat_m1 = 32'(MUL_LAT - 1);
            OP_DIV:  w_lat_m1 = 32'(DIV_LAT - 1);
            default: w_lat_m1 = '0;
        endcase
    end

    arith_unit #(
        .WIDTH (WIDTH)
    ) u_arith_unit (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .result (w_result),
        .div0   (w_div0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= OP_SUM;
            r_a          <= '0;
            r_b          <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;   // requester 0 gets first priority
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_op    <= w_sel_op;
                        r_a     <= w_pick1 ? req1_a : req0_a;
                        r_b     <= w_pick1 ? req1_b : req0_b;
                        r_grant <= w_pick1;
                        r_cnt   <= w_lat_m1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 32'd1;
                    end else begin
                        r_rsp_data <= w_result;
                        r_rsp_err  <= w_div0;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ops_done   <= r_ops_done + 32'd1;
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP) ? {r_grant, ~r_grant} : 2'b00;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = !w_idle;
    assign ops_done  = r_ops_done;

endmodule : arith_op_scheduler
`default_nettype wire
